// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the scan multiplexer family.
//   MODE_MANUAL / MODE_SCAN : encoding of the mode input.
//   clog2_min1()            : $clog2 with a floor of 1, for counters that must
//                             keep at least one bit even when they never count.
// -----------------------------------------------------------------------------
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned result;
        result = $clog2(value);
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/find_next_set.sv
// -----------------------------------------------------------------------------
// find_next_set
// Combinational cyclic search for the next set bit of mask strictly after idx.
// idx itself is the last candidate, so a lone set bit at idx finds itself.
// Ports:
//   idx     (in,  SW) : starting index, must be < N
//   mask    (in,  N)  : candidate bits
//   next    (out, SW) : index found (idx when nothing is set)
//   found   (out, 1)  : at least one mask bit is set
//   wrapped (out, 1)  : found and next <= idx (search went past the top)
// -----------------------------------------------------------------------------
module find_next_set
    import mux_pkg::*;
#(
    parameter int unsigned N = 8,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic [SW-1:0] idx,
    input  logic [N-1:0]  mask,
    output logic [SW-1:0] next,
    output logic          found,
    output logic          wrapped
);

    logic [SW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        next  = idx;
        found = 1'b0;
        cand  = '0;
        for (int unsigned off = N; off >= 1; off--) begin
            cand = SW'((32'(idx) + off) % N);
            if (mask[cand]) begin
                next  = cand;
                found = 1'b1;
            end
        end
        wrapped = found && (next <= idx);
    end

endmodule

// File: rtl/mux_scan_nx1.sv
// -----------------------------------------------------------------------------
// mux_scan_nx1
// Registered N-to-1 multiplexer with manual channel select and auto-scan that
// dwells DWELL cycles on each enabled channel.
// Ports:
//   clk       (in)      : rising-edge clock
//   rst       (in)      : synchronous active-high reset
//   en        (in)      : sample / advance enable
//   mode      (in)      : MODE_MANUAL or MODE_SCAN
//   sel_load  (in)      : load sel_in into the current channel
//   sel_in    (in, SW)  : requested channel, ignored when >= N
//   mask      (in, N)   : per-channel valid bits
//   in_bus    (in, N*W) : channel i at [i*W +: W]
//   out       (out, W)  : registered sample of the current channel
//   out_ch    (out, SW) : channel that produced out
//   out_valid (out, 1)  : out sampled this cycle from an unmasked channel
//   wrap      (out, 1)  : pulse aligned with the first sample after a wrap
// -----------------------------------------------------------------------------
module mux_scan_nx1
    import mux_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned W     = 8,
    parameter int unsigned DWELL = 4,
    localparam int unsigned SW   = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic            sel_load,
    input  logic [SW-1:0]   sel_in,
    input  logic [N-1:0]    mask,
    input  logic [N*W-1:0]  in_bus,
    output logic [W-1:0]    out,
    output logic [SW-1:0]   out_ch,
    output logic            out_valid,
    output logic            wrap
);

    localparam int unsigned DW = clog2_min1(DWELL);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    logic [SW-1:0] cur_ch_q, cur_ch_d;
    logic [DW-1:0] dwell_q, dwell_d;
    // A wrap happens on the edge that moves cur_ch; it is reported one edge
    // later so it lines up with the first sample of the wrapped-to channel.
    logic          wrap_pend_q, wrap_pend_d;

    logic [W-1:0]  ch_data [N];
    logic [SW-1:0] next_ch;
    logic          next_found;
    logic          next_wrapped;
    logic          load_ok;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch_data[i] = in_bus[i*W +: W];
    end

    find_next_set #(
        .N (N)
    ) u_find_next_set (
        .idx     (cur_ch_q),
        .mask    (mask),
        .next    (next_ch),
        .found   (next_found),
        .wrapped (next_wrapped)
    );

    assign load_ok = sel_load && (32'(sel_in) < N);

    always_comb begin
        cur_ch_d    = cur_ch_q;
        dwell_d     = dwell_q;
        wrap_pend_d = wrap_pend_q;
        if (en) begin
            wrap_pend_d = 1'b0;
            if (load_ok) begin
                cur_ch_d = sel_in;
                dwell_d  = '0;
            end else if (mode == MODE_MANUAL) begin
                dwell_d = '0;
            end else if (dwell_q < DWELL_LAST) begin
                dwell_d = dwell_q + 1'b1;
            end else begin
                dwell_d = '0;
                // Empty mask: stay put, keep counting, never wrap.
                if (next_found) begin
                    cur_ch_d    = next_ch;
                    wrap_pend_d = next_wrapped;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_ch_q    <= '0;
            dwell_q     <= '0;
            wrap_pend_q <= 1'b0;
            out         <= '0;
            out_ch      <= '0;
            out_valid   <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            cur_ch_q    <= cur_ch_d;
            dwell_q     <= dwell_d;
            wrap_pend_q <= wrap_pend_d;
            if (en) begin
                // Sample with the pre-update channel.
                out       <= ch_data[cur_ch_q];
                out_ch    <= cur_ch_q;
                out_valid <= mask[cur_ch_q];
                wrap      <= wrap_pend_q;
            end else begin
                out_valid <= 1'b0;
                wrap      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_nx1.sv
module tb_mux_scan_nx1;

    localparam int NCH = 8;
    localparam int WD  = 8;
    localparam int DW  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        mode = 1'b0;
    logic        sel_load = 1'b0;
    logic [2:0]  sel_in = '0;
    logic [7:0]  mask = '0;
    logic [63:0] in_bus = '0;
    logic [7:0]  out;
    logic [2:0]  out_ch;
    logic        out_valid;
    logic        wrap;

    logic [2:0]  sel_in6 = '0;
    logic [5:0]  mask6 = '1;
    logic [47:0] in_bus6 = '0;
    logic [7:0]  out6;
    logic [2:0]  out_ch6;
    logic        out_valid6;
    logic        wrap6;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    int       m_cur, m_cnt;
    bit       m_pend;
    logic [7:0] m_out;
    int       m_och;
    bit       m_valid, m_wrap;

    always #5 clk = ~clk;

    mux_scan_nx1 #(.N(NCH), .W(WD), .DWELL(DW)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_load(sel_load),
        .sel_in(sel_in), .mask(mask), .in_bus(in_bus), .out(out),
        .out_ch(out_ch), .out_valid(out_valid), .wrap(wrap)
    );

    mux_scan_nx1 #(.N(6), .W(8), .DWELL(3)) dut6 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_load(sel_load),
        .sel_in(sel_in6), .mask(mask6), .in_bus(in_bus6), .out(out6),
        .out_ch(out_ch6), .out_valid(out_valid6), .wrap(wrap6)
    );

    // One clock edge: advance the behavioural model from the current inputs,
    // then let the DUT see the same edge and settle.
    task automatic step();
        int nxt;
        bit hit;
        if (rst) begin
            m_cur = 0; m_cnt = 0; m_pend = 0;
            m_out = 0; m_och = 0; m_valid = 0; m_wrap = 0;
        end else if (!en) begin
            m_valid = 0; m_wrap = 0;
        end else begin
            m_out   = in_bus[m_cur*WD +: WD];
            m_och   = m_cur;
            m_valid = mask[m_cur];
            m_wrap  = m_pend;
            m_pend  = 0;
            if (sel_load && int'(sel_in) < NCH) begin
                m_cur = int'(sel_in);
                m_cnt = 0;
            end else if (mode == 1'b0) begin
                m_cnt = 0;
            end else if (m_cnt < DW - 1) begin
                m_cnt++;
            end else begin
                m_cnt = 0;
                hit = 0;
                nxt = m_cur;
                for (int k = 1; k <= NCH && !hit; k++) begin
                    if (mask[(m_cur + k) % NCH]) begin
                        nxt = (m_cur + k) % NCH;
                        hit = 1;
                    end
                end
                if (hit) begin
                    m_pend = (nxt <= m_cur);
                    m_cur  = nxt;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sel_load = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1; mode = 1'b1; mask = 8'hFF; in_bus = {$urandom, $urandom};
        do_reset();
        vectors++;
        if (out !== 8'h00 || out_ch !== 3'd0 || out_valid !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset: out=%h ch=%0d v=%b w=%b, required 00/0/0/0",
                     out, out_ch, out_valid, wrap);
        end
        vectors++;
        if (out6 !== 8'h00 || out_ch6 !== 3'd0 || out_valid6 !== 1'b0 || wrap6 !== 1'b0) begin
            errors++;
            $display("FAIL reset_n6: out=%h ch=%0d v=%b w=%b, required 00/0/0/0",
                     out6, out_ch6, out_valid6, wrap6);
        end
    endtask

    task automatic test_manual_select();
        logic [63:0] bus;
        mode = 1'b0; en = 1'b1; mask = 8'hFF;
        do_reset();
        bus = {$urandom, $urandom};
        bus[5*8 +: 8] = 8'hA5;
        in_bus = bus;
        sel_load = 1'b1; sel_in = 3'd5;
        step();
        sel_load = 1'b0;
        step();
        vectors++;
        if (out !== 8'hA5 || out_ch !== 3'd5 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL manual_select: out=%h ch=%0d v=%b, required A5/5/1",
                     out, out_ch, out_valid);
        end
    endtask

    task automatic test_out_of_range();
        mode = 1'b0; en = 1'b1;
        do_reset();
        sel_load = 1'b1; sel_in6 = 3'd4;
        step();
        sel_load = 1'b0;
        step();
        vectors++;
        if (out_ch6 !== 3'd4) begin
            errors++;
            $display("FAIL oor_setup: out_ch=%0d, required 4", out_ch6);
        end
        for (int v = 6; v <= 7; v++) begin
            sel_load = 1'b1; sel_in6 = 3'(v);
            step();
            sel_load = 1'b0;
            step();
            vectors++;
            if (out_ch6 !== 3'd4) begin
                errors++;
                $display("FAIL oor_load_%0d: out_ch=%0d, required 4", v, out_ch6);
            end
        end
        sel_load = 1'b1; sel_in6 = 3'd5;
        step();
        sel_load = 1'b0;
        step();
        vectors++;
        if (out_ch6 !== 3'd5) begin
            errors++;
            $display("FAIL oor_edge_5: out_ch=%0d, required 5", out_ch6);
        end
    endtask

    task automatic test_scan_full();
        mode = 1'b1; en = 1'b1; mask = 8'hFF;
        do_reset();
        for (int j = 0; j <= 36; j++) begin
            in_bus = {$urandom, $urandom};
            step();
            vectors++;
            if (out_ch !== 3'((j / 4) % 8) || wrap !== (j == 32) || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL scan_full[%0d]: ch=%0d w=%b v=%b, required %0d/%b/1",
                         j, out_ch, wrap, out_valid, (j / 4) % 8, (j == 32));
            end
        end
    endtask

    task automatic test_sparse();
        int exp_ch;
        mode = 1'b1; en = 1'b1; mask = 8'h24;
        do_reset();
        for (int j = 0; j < 24; j++) begin
            step();
            if (j < 4) exp_ch = 0;
            else exp_ch = (((j - 4) / 4) % 2 == 0) ? 2 : 5;
            vectors++;
            if (out_ch !== 3'(exp_ch) || out_valid !== (j >= 4) ||
                wrap !== (j == 12 || j == 20)) begin
                errors++;
                $display("FAIL sparse[%0d]: ch=%0d v=%b w=%b, required %0d/%b/%b",
                         j, out_ch, out_valid, wrap, exp_ch, (j >= 4), (j == 12 || j == 20));
            end
        end
    endtask

    task automatic test_mask_zero();
        mode = 1'b1; en = 1'b1; mask = 8'h00;
        do_reset();
        for (int j = 0; j < 12; j++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0 || wrap !== 1'b0 || out_ch !== 3'd0) begin
                errors++;
                $display("FAIL mask_zero[%0d]: v=%b w=%b ch=%0d, required 0/0/0",
                         j, out_valid, wrap, out_ch);
            end
        end
    endtask

    task automatic test_en_hold();
        logic [7:0] held;
        int exp_resume [3] = '{1, 1, 2};
        mode = 1'b1; en = 1'b1; mask = 8'hFF;
        do_reset();
        held = '0;
        for (int j = 0; j < 6; j++) begin
            in_bus = {$urandom, $urandom};
            held = in_bus[(j / 4) * 8 +: 8];
            step();
        end
        en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_bus = {$urandom, $urandom};
            step();
            vectors++;
            if (out !== held || out_ch !== 3'd1 || out_valid !== 1'b0 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL en_hold[%0d]: out=%h ch=%0d v=%b w=%b, required %h/1/0/0",
                         j, out, out_ch, out_valid, wrap, held);
            end
        end
        en = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            vectors++;
            if (out_ch !== 3'(exp_resume[j]) || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL en_resume[%0d]: ch=%0d v=%b, required %0d/1",
                         j, out_ch, out_valid, exp_resume[j]);
            end
        end
    endtask

    task automatic test_priority_reset();
        mode = 1'b1; en = 1'b1; mask = 8'hFF;
        do_reset();
        for (int j = 0; j < 3; j++) step();
        sel_load = 1'b1; sel_in = 3'd3;
        step();
        sel_load = 1'b0;
        vectors++;
        if (out_ch !== 3'd0) begin
            errors++;
            $display("FAIL prio_sample: ch=%0d, required 0", out_ch);
        end
        for (int j = 0; j < 5; j++) begin
            in_bus = {$urandom, $urandom};
            step();
            vectors++;
            if (out_ch !== ((j < 4) ? 3'd3 : 3'd4) || wrap !== 1'b0) begin
                errors++;
                $display("FAIL prio_dwell[%0d]: ch=%0d w=%b, required %0d/0",
                         j, out_ch, wrap, (j < 4) ? 3 : 4);
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (out !== 8'h00 || out_ch !== 3'd0 || out_valid !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL mid_scan_reset: out=%h ch=%0d v=%b w=%b, required 00/0/0/0",
                     out, out_ch, out_valid, wrap);
        end
    endtask

    task automatic test_random();
        mask = 8'hFF;
        do_reset();
        for (int j = 0; j < 400; j++) begin
            in_bus   = {$urandom, $urandom};
            rst      = ($urandom_range(0, 99) < 2);
            en       = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 99) < 5) mode = ~mode;
            sel_load = ($urandom_range(0, 99) < 8);
            sel_in   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 6) mask = 8'($urandom);
            step();
            vectors++;
            if (out !== m_out || out_ch !== 3'(m_och) || out_valid !== m_valid ||
                wrap !== m_wrap) begin
                errors++;
                $display("FAIL random[%0d]: out=%h ch=%0d v=%b w=%b, required %h/%0d/%b/%b",
                         j, out, out_ch, out_valid, wrap, m_out, m_och, m_valid, m_wrap);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_manual_select();
        test_out_of_range();
        test_scan_full();
        test_sparse();
        test_mask_zero();
        test_en_hold();
        test_priority_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
